// File: rtl/monitor_stage_pipe.sv
// monitor_stage_pipe: symbol/restart delay line plus report capture into sticky flags and an event FIFO.
// Define MONITOR_STAGE_TIMESTAMP_EN to build the cycle counter and carry stamps in evt_cycle.
module monitor_stage_pipe #(
   parameter int unsigned SYMBOL_W    = 8,
   parameter int unsigned NUM_REPORTS = 40,
   parameter int unsigned PIPE_DEPTH  = 1,
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned CYC_W       = 32,
   localparam int unsigned ID_W       = (NUM_REPORTS > 1) ? $clog2(NUM_REPORTS) : 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   run,
   input  logic                   in_reset,
   input  logic [SYMBOL_W-1:0]    in_symbols,
   input  logic [NUM_REPORTS-1:0] report_vec,
   input  logic                   clear_sticky,
   output logic [SYMBOL_W-1:0]    out_symbols,
   output logic                   out_reset,
   output logic [NUM_REPORTS-1:0] sticky_reports,
   output logic                   evt_valid,
   input  logic                   evt_ready,
   output logic [ID_W-1:0]        evt_id,
   output logic [ID_W:0]          evt_count,
   output logic [CYC_W-1:0]       evt_cycle,
   output logic                   evt_overflow
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = ID_W + 1;
`ifdef MONITOR_STAGE_TIMESTAMP_EN
   localparam int unsigned ENT_W = ID_W + CNT_W + CYC_W;
`else
   localparam int unsigned ENT_W = ID_W + CNT_W;
`endif
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W:0]   FILL_ONE = (PTR_W + 1)'(1);
   localparam logic [PTR_W:0]   FILL_MAX = (PTR_W + 1)'(FIFO_DEPTH);

   logic [SYMBOL_W-1:0]    r_sym [PIPE_DEPTH];
   logic [PIPE_DEPTH-1:0]  r_rst;
   logic [NUM_REPORTS-1:0] r_sticky;
   logic                   r_ovf;

   logic [ENT_W-1:0]       r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]       r_wptr;
   logic [PTR_W-1:0]       r_rptr;
   logic [PTR_W:0]         r_fill;
   logic [ENT_W-1:0]       r_head;
   logic                   r_valid;

   logic [ID_W-1:0]        w_id;
   logic [CNT_W-1:0]       w_pop_cnt;
   logic [ENT_W-1:0]       w_entry;
   logic                   w_event;
   logic                   w_pop;
   logic                   w_full;
   logic                   w_accept;
   logic                   w_drop;
   logic [PTR_W-1:0]       w_rptr_nxt;
   logic [PTR_W:0]         w_fill_nxt;
   logic [ENT_W-1:0]       w_head_nxt;

   // Symbols advance only on run; the restart flag advances every clock.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < PIPE_DEPTH; i++) r_sym[i] <= '0;
         r_rst <= '0;
      end else begin
         if (run) begin
            r_sym[0] <= in_symbols;
            for (int i = 1; i < PIPE_DEPTH; i++) r_sym[i] <= r_sym[i-1];
         end
         r_rst[0] <= in_reset;
         for (int i = 1; i < PIPE_DEPTH; i++) r_rst[i] <= r_rst[i-1];
      end
   end

   always_comb begin
      w_id      = '0;
      w_pop_cnt = '0;
      for (int i = NUM_REPORTS - 1; i >= 0; i--) begin
         if (report_vec[i]) w_id = ID_W'(i);
         w_pop_cnt = w_pop_cnt + CNT_W'(report_vec[i]);
      end
   end

`ifdef MONITOR_STAGE_TIMESTAMP_EN
   logic [CYC_W-1:0] r_cyc;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cyc <= '0;
      end else if (run) begin
         r_cyc <= in_reset ? '0 : r_cyc + CYC_W'(1);
      end
   end

   assign w_entry = {w_id, w_pop_cnt, r_cyc};
`else
   assign w_entry = {w_id, w_pop_cnt};
`endif

   assign w_event  = run & (|report_vec);
   assign w_pop    = r_valid & evt_ready;
   assign w_full   = (r_fill == FILL_MAX);
   assign w_accept = w_event & (~w_full | w_pop);
   assign w_drop   = w_event & ~w_accept;

   // Head register is loaded from the post-update FIFO state; a push landing at the new
   // read pointer is forwarded from the incoming entry since memory is not yet written.
   always_comb begin
      w_rptr_nxt = w_pop ? r_rptr + PTR_ONE : r_rptr;
      w_fill_nxt = r_fill;
      if (w_accept && !w_pop) begin
         w_fill_nxt = r_fill + FILL_ONE;
      end else if (!w_accept && w_pop) begin
         w_fill_nxt = r_fill - FILL_ONE;
      end
      w_head_nxt = '0;
      if (w_fill_nxt != '0) begin
         if (w_accept && (w_rptr_nxt == r_wptr)) w_head_nxt = w_entry;
         else                                    w_head_nxt = r_mem[w_rptr_nxt];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_fill  <= '0;
         r_head  <= '0;
         r_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_mem[r_wptr] <= w_entry;
            r_wptr        <= r_wptr + PTR_ONE;
         end
         r_rptr  <= w_rptr_nxt;
         r_fill  <= w_fill_nxt;
         r_head  <= w_head_nxt;
         r_valid <= (w_fill_nxt != '0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sticky <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_sticky <= (clear_sticky ? '0 : r_sticky) | (run ? report_vec : '0);
         r_ovf    <= w_drop | (r_ovf & ~clear_sticky);
      end
   end

   assign out_symbols    = r_sym[PIPE_DEPTH-1];
   assign out_reset      = r_rst[PIPE_DEPTH-1];
   assign sticky_reports = r_sticky;
   assign evt_overflow   = r_ovf;
   assign evt_valid      = r_valid;
   assign evt_id         = r_head[ENT_W-1 -: ID_W];
   assign evt_count      = r_head[ENT_W-ID_W-1 -: CNT_W];
`ifdef MONITOR_STAGE_TIMESTAMP_EN
   assign evt_cycle      = r_head[CYC_W-1:0];
`else
   assign evt_cycle      = '0;
`endif

endmodule
